// File: rtl/pipe_stage_skid_reg.sv
// Purpose: parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush-to-bubble and saturating perf counters.
// Latency: 1 cycle from acceptance (in_valid && in_ready) to out_valid; 1 entry/cycle sustained while out_ready stays high.
// Backpressure: a second entry is absorbed into the skid register; in_ready drops while both entries are held, during flush and during rst.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   flush                    discard all held entries this cycle (bubble insert)
//   in_valid/in_ready        upstream handshake; in_data/in_ctrl sampled on transfer only
//   out_valid/out_ready      downstream handshake; out_data/out_ctrl come from the main register
//   stall_cnt                cycles with out_valid && !out_ready, saturating
//   flush_cnt                valid entries discarded by flush, saturating
module pipe_stage_skid_reg #(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 12,
    parameter int CNT_W      = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              acc;
    logic              drn;
    logic [1:0]        discard;
    logic [CNT_W:0]    flush_sum;
    logic [DATA_W-1:0] data_kill;

    // Ready depends only on registered state, flush and rst so it never
    // forms a combinational path from in_valid or out_ready.
    assign in_ready  = !rst && (state != SKID) && !flush;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

    assign acc = in_valid && in_ready;
    assign drn = out_valid && out_ready;

    // Value written into a data register when its entry is invalidated.
    assign data_kill = '0;

    // Entries lost to a flush: the skid entry always, the main entry only
    // if it is not being delivered downstream in the same cycle.
    always_comb begin
        discard = 2'd0;
        if (state == SKID) begin
            discard = discard + 2'd1;
        end
        if ((state != EMPTY) && !drn) begin
            discard = discard + 2'd1;
        end
        flush_sum = {1'b0, flush_cnt} + {{(CNT_W-1){1'b0}}, discard};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (flush) begin
                state     <= EMPTY;
                main_ctrl <= '0;
                skid_ctrl <= '0;
                if (CLEAR_DATA) begin
                    main_data <= data_kill;
                    skid_data <= data_kill;
                end
                flush_cnt <= flush_sum[CNT_W] ? CNT_MAX : flush_sum[CNT_W-1:0];
            end else begin
                case (state)
                    EMPTY: begin
                        if (acc) begin
                            state     <= FULL;
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end
                    end
                    FULL: begin
                        if (acc && drn) begin
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end else if (acc) begin
                            // Downstream stalled: park the new entry behind main.
                            state     <= SKID;
                            skid_data <= in_data;
                            skid_ctrl <= in_ctrl;
                        end else if (drn) begin
                            state     <= EMPTY;
                            main_ctrl <= '0;
                            if (CLEAR_DATA) begin
                                main_data <= data_kill;
                            end
                        end
                    end
                    SKID: begin
                        if (drn) begin
                            state     <= FULL;
                            main_data <= skid_data;
                            main_ctrl <= skid_ctrl;
                            skid_ctrl <= '0;
                            if (CLEAR_DATA) begin
                                skid_data <= data_kill;
                            end
                        end
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

    localparam int DW  = 16;
    localparam int CW  = 8;
    localparam int NW  = 4;
    localparam int SAT = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .DATA_W(DW), .CTRL_W(CW), .CNT_W(NW), .CLEAR_DATA(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Reference model: the stage is an ordered queue holding at most two entries.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] delivered[$];
    int            m_stall;
    int            m_flush;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic int clamp(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check against the model, then advance the model at posedge.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [DW-1:0] id, input logic [CW-1:0] ic, input logic ordy);
        logic m_vld, m_rdy, drn, acc;
        int   disc;
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = iv ? id : 'x;
        in_ctrl   = iv ? ic : 'x;
        out_ready = ordy;
        #1;
        m_vld = (q.size() > 0);
        m_rdy = !r && (q.size() < 2) && !f;
        chk("in_ready",  {63'd0, in_ready}, {63'd0, m_rdy});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_vld});
        chk("out_data",  64'(out_data), m_vld ? 64'(q[0].d) : 64'd0);
        chk("out_ctrl",  64'(out_ctrl), m_vld ? 64'(q[0].c) : 64'd0);
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        drn = m_vld && ordy;
        acc = iv && m_rdy;
        if (!r && drn) delivered.push_back(out_data);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (m_vld && !ordy) m_stall = clamp(m_stall + 1);
            if (f) begin
                disc    = q.size() - (drn ? 1 : 0);
                m_flush = clamp(m_flush + disc);
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back('{id, ic});
            end
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic          r_f, r_iv, r_or, r_r;
        logic [DW-1:0] r_d;
        logic [CW-1:0] r_c;

        // Power-up reset without checks: the DUT state is unknown until the first edge.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        q.delete(); m_stall = 0; m_flush = 0;

        // Reset state.
        do_reset();
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        // Streaming at full throughput.
        delivered.delete();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, DW'(i), CW'(i + 1), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        #2;
        chk("stream_count", 64'(delivered.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk("stream_order", 64'(delivered[i]), 64'(i));
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Back-pressure: A,B,C with downstream stalled, B parks in the skid register.
        do_reset();
        delivered.delete();
        cyc(1'b0, 1'b0, 1'b1, 16'hA0A0, 8'hA1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'hB0B0, 8'hB1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'hC0C0, 8'hC1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'hC0C0, 8'hC1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'hC0C0, 8'hC1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'hC0C0, 8'hC1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        #2;
        chk("abc_count", 64'(delivered.size()), 64'd3);
        if (delivered.size() == 3) begin
            chk("abc_0", 64'(delivered[0]), 64'hA0A0);
            chk("abc_1", 64'(delivered[1]), 64'hB0B0);
            chk("abc_2", 64'(delivered[2]), 64'hC0C0);
        end
        chk("abc_stall", 64'(stall_cnt), 64'd3);

        // Flush in SKID with downstream stalled discards two entries.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 16'h1111, 8'h11, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h2222, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'h3333, 8'h33, 1'b0);
        #2;
        chk("flush2_cnt", 64'(flush_cnt), 64'd2);
        chk("flush2_data", 64'(out_data), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Flush while main is delivered: nothing counted, nothing accepted.
        do_reset();
        delivered.delete();
        cyc(1'b0, 1'b0, 1'b1, 16'h4444, 8'h44, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'h5555, 8'h55, 1'b1);
        #2;
        chk("flushdrn_cnt", 64'(flush_cnt), 64'd0);
        chk("flushdrn_vld", {63'd0, out_valid}, 64'd0);
        chk("flushdrn_dlv", 64'(delivered.size()), 64'd1);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Counter saturation.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 16'h6666, 8'h66, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        chk("stall_sat", 64'(stall_cnt), 64'(SAT));
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b0, 1'b1, DW'(i), CW'(i), 1'b0);
            cyc(1'b0, 1'b0, 1'b1, DW'(i + 16), CW'(i), 1'b0);
            cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        end
        #2;
        chk("flush_sat", 64'(flush_cnt), 64'(SAT));

        // Reset while in SKID with upstream still offering.
        cyc(1'b0, 1'b0, 1'b1, 16'h7777, 8'h77, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h8888, 8'h88, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h9999, 8'h99, 1'b0);
        #2;
        chk("rstskid_vld", {63'd0, out_valid}, 64'd0);
        chk("rstskid_stall", 64'(stall_cnt), 64'd0);
        chk("rstskid_flush", 64'(flush_cnt), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r_r  = ($urandom_range(0, 199) == 0);
            r_f  = ($urandom_range(0, 15) == 0);
            r_iv = ($urandom_range(0, 3) != 0);
            r_or = ($urandom_range(0, 2) != 0);
            r_d  = DW'($urandom);
            r_c  = CW'($urandom);
            cyc(r_r, r_f, r_iv, r_d, r_c, r_or);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register for the multi-cycle/pipelined datapath, replacing the fixed per-stage register banks (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary data bus and a control bus. It adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not lose instructions. A flush inserts a bubble, with all control bits zeroed. Saturating stall and flush counters provide performance monitoring.

Parameters:
DATA_W, 64, width of the data payload (e.g. aluResult+rfOut2 concatenation)
CTRL_W, 12, width of the control payload (RegWrite, MemWrite, MemRead, ... packed)
CNT_W, 16, width of each performance counter
CLEAR_DATA, 1, 1: data payload zeroed whenever an entry is invalidated; 0: data held

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries this cycle (branch/exception)
in_valid  in  1  upstream presents an entry
in_ready  out  1  stage can accept; transfer when in_valid && in_ready
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
out_data  out  DATA_W  output data payload
out_ctrl  out  CTRL_W  output control payload; all-zero whenever out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating
flush_cnt  out  CNT_W  valid entries discarded by flush, saturating

Behaviour:
- Reset, synchronous on posedge with rst=1; rst beats every other input:
  - state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid contents=0, stall_cnt=0, flush_cnt=0.
  - in_ready=0 while rst=1; 1 on the first cycle after reset.
  - Reset mid-transfer discards both entries without counting them.
- Storage: main register drives out_*; skid register is internal.
- States:
  - EMPTY: main invalid.
  - FULL: main valid.
  - SKID: main and skid valid.
- in_ready = (state != SKID) && !flush. It is combinational from registered state and flush only, never from in_valid or out_ready.
- Define acc = in_valid && in_ready, and drn = out_valid && out_ready.
- Transitions when flush=0:
  - EMPTY: acc -> FULL, main<=in.
  - FULL: acc && drn -> FULL, main<=in. acc && !drn -> SKID, skid<=in. !acc && drn -> EMPTY. Otherwise hold.
  - SKID: drn -> FULL, main<=skid, skid cleared. Otherwise hold; in_ready=0.
- Latency: 1 cycle from acceptance to out_valid. With out_ready held high, full throughput of 1 entry/cycle.
- Ordering is strict FIFO. The skid entry never overtakes main.
- Flush (rst=0, flush=1):
  - Next state EMPTY; main and skid invalidated.
  - No input is accepted that cycle (in_ready=0).
  - A downstream drn in the same cycle still completes; the entry counts as delivered, not flushed.
- Invalidation: whenever an entry becomes invalid (drain to EMPTY, flush, skid move), its ctrl is zeroed. Its data is zeroed iff CLEAR_DATA=1. Result: out_ctrl==0 whenever out_valid==0 (bubble with RegWrite/MemWrite=0).
- stall_cnt: +1 on each cycle with out_valid && !out_ready && !rst. Saturates at 2^CNT_W-1, no wrap.
- flush_cnt: on flush, adds the number of valid entries discarded (0, 1 or 2; main excluded if drn that cycle). Saturating add, clamps at all-ones.
- in_data/in_ctrl are sampled only on acc; X on unused cycles must not propagate.

Test Plan:
- Reset, then 8 entries data=i, ctrl=i+1, in_valid=1 and out_ready=1 every cycle -> out_valid 1 cycle after each accept, out_data 0..7 in order, in_ready constantly 1, stall_cnt=0.
- Stream A,B,C with out_ready=0 from the cycle A appears on the output:
  - B lands in skid, in_ready falls, C is held upstream.
  - Raise out_ready -> outputs A,B,C in order, none lost or duplicated.
  - stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- SKID state (2 valid entries) and flush=1 with out_ready=0 -> next cycle out_valid=0, out_ctrl=0, out_data=0 (CLEAR_DATA=1), flush_cnt=2, in_ready=1.
- FULL with out_ready=1, flush=1 and in_valid=1 in the same cycle -> main delivered, input not accepted, flush_cnt unchanged, state EMPTY.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15. Repeated double flushes -> flush_cnt clamps at 15.
- rst=1 asserted while in SKID with in_valid=1 -> next cycle out_valid=0, all counters 0, in_ready=0 during rst and 1 the cycle after release.
